fetch_decode: RTL

Multi-cycle instruction fetch/decode sequencer that sits directly upstream of the 16-bit datapath (register file, ALU control, ALU). It owns the PC, fetches one 16-bit instruction per pass over a req/ack memory port, latches it in an instruction register and drives the datapath's opcode, opext, register addresses, immediate and regwrite. Each instruction moves through FETCH, DECODE, EXEC and WB; the datapath consumes the decoded fields.

---
 rtl/fetch_decode_if.sv | 14 +
 rtl/fetch_decode.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_decode_if.sv
// Instruction memory read port between the fetch sequencer (master) and memory (slave).
// The request stays high until ack. Ack is only meaningful while the request is high.
interface fetch_decode_if #(
   parameter int WIDTH    = 16,
   parameter int ADDRBITS = 16
);
   logic                mem_req;
   logic [ADDRBITS-1:0] mem_addr;
   logic                mem_ack;
   logic [WIDTH-1:0]    mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode sequencer: FETCH -> DECODE -> EXEC -> WB (-> STALL).
// It owns the PC and the instruction register, and it drives the decoded fields to the 16-bit datapath.
module fetch_decode #(
   parameter int WIDTH    = 16,
   parameter int REGBITS  = 4,
   parameter int ADDRBITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   fetch_decode_if.master      bus,
   input  logic                stall,
   input  logic                pc_load,
   input  logic [ADDRBITS-1:0] pc_target,
   output logic [3:0]          opcode,
   output logic [3:0]          opext,
   output logic [REGBITS-1:0]  ra1,
   output logic [REGBITS-1:0]  ra2,
   output logic [REGBITS-1:0]  wa,
   output logic [WIDTH-1:0]    imm,
   output logic                use_imm,
   output logic                regwrite,
   output logic                illegal,
   output logic [ADDRBITS-1:0] pc
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_STALL} state_t;

   state_t              state;
   logic [WIDTH-1:0]    ir;
   logic [ADDRBITS-1:0] pc_r;
   logic                req_r;

   function automatic logic is_zext_imm(input logic [3:0] op);
      return (op == 4'h1) || (op == 4'h2) || (op == 4'h3) || (op == 4'hD);
   endfunction

   function automatic logic is_sext_imm(input logic [3:0] op);
      return (op == 4'h5) || (op == 4'h9) || (op == 4'hB);
   endfunction

   function automatic logic [WIDTH-1:0] sext8(input logic signed [7:0] v);
      logic signed [WIDTH-1:0] t;
      t = v;
      return t;
   endfunction

   function automatic logic [WIDTH-1:0] zext8(input logic [7:0] v);
      return WIDTH'(v);
   endfunction

   // req_r is cleared by reset, so the first request appears one edge after reset is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_FETCH;
         pc_r  <= '0;
         ir    <= '0;
         req_r <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (req_r && bus.mem_ack) begin
                  ir    <= bus.mem_rdata;
                  state <= S_DECODE;
                  req_r <= 1'b0;
               end else begin
                  req_r <= 1'b1;
               end
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC:   state <= S_WB;
            S_WB: begin
               pc_r <= pc_load ? pc_target : pc_r + ADDRBITS'(1);
               if (stall) begin
                  state <= S_STALL;
               end else begin
                  state <= S_FETCH;
                  req_r <= 1'b1;
               end
            end
            S_STALL: begin
               if (!stall) begin
                  state <= S_FETCH;
                  req_r <= 1'b1;
               end
            end
            default: begin
               state <= S_FETCH;
               req_r <= 1'b0;
            end
         endcase
      end
   end

   logic op_defined;
   logic writes;

   always_comb begin
      op_defined = (ir[15:12] == 4'h0) || is_zext_imm(ir[15:12]) || is_sext_imm(ir[15:12]);
      // NOP, CMP and CMPI only set flags, so they never write a register.
      writes     = op_defined && (ir != '0) &&
                   !((ir[15:12] == 4'h0) && (ir[7:4] == 4'hB)) && (ir[15:12] != 4'hB);
      imm        = '0;
      if (is_zext_imm(ir[15:12])) imm = zext8(ir[7:0]);
      if (is_sext_imm(ir[15:12])) imm = sext8(ir[7:0]);
   end

   assign use_imm      = is_zext_imm(ir[15:12]) || is_sext_imm(ir[15:12]);
   assign opcode       = ir[15:12];
   assign opext        = ir[7:4];
   assign ra1          = REGBITS'(ir[11:8]);
   assign ra2          = REGBITS'(ir[3:0]);
   assign wa           = REGBITS'(ir[11:8]);
   assign regwrite     = (state == S_WB) && writes;
   assign illegal      = (state == S_DECODE) && !op_defined;
   assign pc           = pc_r;
   assign bus.mem_req  = req_r;
   assign bus.mem_addr = pc_r;

endmodule
